// File: rtl/ssd_digit_mux.sv
// ssd_digit_mux
// Qualifies raw keypad presses and shifts each accepted key into a two-digit
// buffer. It also drives the SSD digit select and presents the selected
// digit nibble to disp_ctrl.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous, active-high reset
//   key_val     decoded key code from keypad_decoder
//   key_valid   high while keypad_decoder reports a pressed key
//   clear       single-cycle pulse, zeroes both digits on the next edge
//   auto_mux    1 = chip_sel toggled by the refresh counter, 0 = manual
//   sel_toggle  single-cycle pulse, toggles chip_sel in manual mode only
//   disp_val    selected digit nibble (left when chip_sel=1, else right)
//   chip_sel    digit select, 0 = right digit, 1 = left digit
//   key_event   one-cycle pulse when a key is accepted
//   digit_right most recently accepted key
//   digit_left  previously accepted key
module ssd_digit_mux #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int HOLD_MS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  input  logic       key_valid,
  input  logic       clear,
  input  logic       auto_mux,
  input  logic       sel_toggle,
  output logic [3:0] disp_val,
  output logic       chip_sel,
  output logic       key_event,
  output logic [3:0] digit_right,
  output logic [3:0] digit_left
);

  localparam int DIV  = CLK_FREQ / REFRESH_HZ;
  localparam int HOLD = (CLK_FREQ / 1000) * HOLD_MS;
  localparam int RW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW   = $clog2(HOLD + 1);

  localparam logic [RW-1:0] REF_LAST  = RW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] CNT_ONE   = HW'(1);

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    CAPTURED,
    RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_right_q, digit_right_d;
  logic [3:0]    digit_left_q, digit_left_d;
  logic          key_event_q, key_event_d;
  logic          chip_sel_q, chip_sel_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          capture;
  logic          ref_wrap;

  // State register and all datapath flops. Reset is asynchronous so a
  // partially qualified key is dropped the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      digit_right_q <= '0;
      digit_left_q  <= '0;
      key_event_q   <= 1'b0;
      chip_sel_q    <= 1'b0;
      ref_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      digit_right_q <= digit_right_d;
      digit_left_q  <= digit_left_d;
      key_event_q   <= key_event_d;
      chip_sel_q    <= chip_sel_d;
      ref_cnt_q     <= ref_cnt_d;
    end
  end

  // Next-state logic of the key qualifier. The hold counter counts stable
  // cycles and reaching HOLD on this edge is what triggers the capture or
  // the return to IDLE. It never goes past HOLD.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = QUALIFY;
          cand_d  = key_val;
          cnt_d   = CNT_ONE;
        end
      end
      QUALIFY: begin
        if (!key_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (key_val != cand_q) begin
          // A changing code restarts the window with the new candidate.
          cand_d = key_val;
          cnt_d  = CNT_ONE;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = CAPTURED;
          cnt_d   = HOLD_MAX;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CAPTURED: begin
        // Holding the key never re-captures, so there is no auto-repeat.
        if (!key_valid) begin
          state_d = RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE: begin
        if (key_valid) begin
          // Release bounce: back to CAPTURED without a new capture.
          state_d = CAPTURED;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = HOLD_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output and datapath logic: the digit shift register (clear has priority
  // over a coincident capture, but the event still pulses), the free-running
  // refresh counter, and the chip_sel toggling for both modes.
  always_comb begin
    digit_right_d = digit_right_q;
    digit_left_d  = digit_left_q;
    key_event_d   = capture;
    ref_wrap      = (ref_cnt_q == REF_LAST);
    ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + RW'(1);
    chip_sel_d    = chip_sel_q;

    if (clear) begin
      digit_right_d = '0;
      digit_left_d  = '0;
    end else if (capture) begin
      digit_left_d  = digit_right_q;
      digit_right_d = cand_q;
    end

    if (auto_mux) begin
      if (ref_wrap) chip_sel_d = ~chip_sel_q;
    end else if (sel_toggle) begin
      chip_sel_d = ~chip_sel_q;
    end
  end

  assign chip_sel    = chip_sel_q;
  assign key_event   = key_event_q;
  assign digit_right = digit_right_q;
  assign digit_left  = digit_left_q;
  assign disp_val    = chip_sel_q ? digit_left_q : digit_right_q;

endmodule

// File: tb/tb_ssd_digit_mux.sv
// tb_ssd_digit_mux
// Self-checking bench for ssd_digit_mux with CLK_FREQ=1000, REFRESH_HZ=100
// and HOLD_MS=5, giving DIV=10 and HOLD=5. Directed vector tables and
// hand-written sequences are followed by a randomized run. The randomized
// run is compared against a behavioural model built from run lengths.
module tb_ssd_digit_mux;

  localparam int CLK_FREQ   = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int HOLD_MS    = 5;
  localparam int DIV        = CLK_FREQ / REFRESH_HZ;
  localparam int HOLD       = (CLK_FREQ / 1000) * HOLD_MS;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_val;
  logic       key_valid;
  logic       clear;
  logic       auto_mux;
  logic       sel_toggle;
  logic [3:0] disp_val;
  logic       chip_sel;
  logic       key_event;
  logic [3:0] digit_right;
  logic [3:0] digit_left;

  int assert_count = 0;
  int fail_count   = 0;

  // Behavioural model state: a key is accepted once it has been seen for
  // HOLD consecutive cycles with the same code while armed. After that the
  // model re-arms only after HOLD consecutive cycles without key_valid.
  bit         m_armed;
  int         m_run;
  logic [3:0] m_run_key;
  int         m_low;
  logic [3:0] m_right;
  logic [3:0] m_left;
  logic       m_event;
  logic       m_chip;
  int         m_cycles;
  bit         compare_model = 1'b0;

  typedef struct {
    logic       kv;
    logic [3:0] key;
    int         cycles;
    int         exp_events;
    logic [3:0] exp_right;
    logic [3:0] exp_left;
  } vec_t;

  vec_t vecs[$];

  ssd_digit_mux #(
    .CLK_FREQ  (CLK_FREQ),
    .REFRESH_HZ(REFRESH_HZ),
    .HOLD_MS   (HOLD_MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_val    (key_val),
    .key_valid  (key_valid),
    .clear      (clear),
    .auto_mux   (auto_mux),
    .sel_toggle (sel_toggle),
    .disp_val   (disp_val),
    .chip_sel   (chip_sel),
    .key_event  (key_event),
    .digit_right(digit_right),
    .digit_left (digit_left)
  );

  always #5 clk = ~clk;

  // Compare one observed value with the value the bench worked out itself.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [3:0] k,
                               input logic clr, input logic am,
                               input logic st);
    key_valid  = kv;
    key_val    = k;
    clear      = clr;
    auto_mux   = am;
    sel_toggle = st;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic modelStep();
    bit cap;
    cap = 1'b0;
    if (rst) begin
      m_armed  = 1'b1;
      m_run    = 0;
      m_run_key = 4'h0;
      m_low    = 0;
      m_right  = 4'h0;
      m_left   = 4'h0;
      m_event  = 1'b0;
      m_chip   = 1'b0;
      m_cycles = 0;
    end else begin
      if (m_armed) begin
        if (key_valid) begin
          if (m_run > 0 && key_val == m_run_key) m_run++;
          else begin
            m_run     = 1;
            m_run_key = key_val;
          end
          if (m_run == HOLD) begin
            cap     = 1'b1;
            m_armed = 1'b0;
            m_low   = 0;
            m_run   = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (key_valid) m_low = 0;
        else begin
          m_low++;
          if (m_low == HOLD) begin
            m_armed = 1'b1;
            m_run   = 0;
          end
        end
      end
      if (clear) begin
        m_right = 4'h0;
        m_left  = 4'h0;
      end else if (cap) begin
        m_left  = m_right;
        m_right = m_run_key;
      end
      m_event = cap;
      if (auto_mux) begin
        if ((m_cycles % DIV) == DIV - 1) m_chip = ~m_chip;
      end else if (sel_toggle) begin
        m_chip = ~m_chip;
      end
      m_cycles++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    if (compare_model) begin
      checkOutput("rand_key_event", key_event, m_event);
      checkOutput("rand_digit_right", digit_right, m_right);
      checkOutput("rand_digit_left", digit_left, m_left);
      checkOutput("rand_chip_sel", chip_sel, m_chip);
      checkOutput("rand_disp_val", disp_val, m_chip ? m_left : m_right);
    end
  endtask

  task automatic addVec(input logic kv, input logic [3:0] k, input int cyc,
                        input int ev, input logic [3:0] r, input logic [3:0] l);
    vec_t v;
    v.kv = kv; v.key = k; v.cycles = cyc; v.exp_events = ev;
    v.exp_right = r; v.exp_left = l;
    vecs.push_back(v);
  endtask

  initial begin
    int ev;
    int first_ev;
    int toggles;
    int last_toggle;
    int bad_gap;
    logic prev_chip;
    logic seg_kv;
    logic [3:0] seg_key;
    int seg_left;
    logic rand_am;

    // Reset is asynchronous: outputs must be at reset values before any edge.
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_digit_right", digit_right, 4'h0);
    checkOutput("reset_digit_left", digit_left, 4'h0);
    checkOutput("reset_chip_sel", chip_sel, 1'b0);
    checkOutput("reset_key_event", key_event, 1'b0);
    checkOutput("reset_disp_val", disp_val, 4'h0);
    tick();
    tick();
    rst = 1'b0;

    // Key 7 held 20 cycles: exactly one event, HOLD cycles after the rise.
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    ev = 0;
    first_ev = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_event) begin
        ev++;
        if (first_ev < 0) first_ev = i;
      end
    end
    checkOutput("t1_latency", first_ev, HOLD);
    checkOutput("t1_event_count", ev, 1);
    applyStimulus(1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t1_digit_right", digit_right, 4'h7);
    checkOutput("t1_digit_left", digit_left, 4'h0);

    // Vector table: press 3 then 9, the alternating 2/5 bounce,
    // and key 8 with a short dropout that must not re-capture.
    addVec(1'b1, 4'h3, 6, 1, 4'h3, 4'h7);
    addVec(1'b0, 4'h3, 6, 0, 4'h3, 4'h7);
    addVec(1'b1, 4'h9, 6, 1, 4'h9, 4'h3);
    addVec(1'b0, 4'h9, 6, 0, 4'h9, 4'h3);
    for (int i = 0; i < 5; i++) begin
      addVec(1'b1, 4'h2, 3, 0, 4'h9, 4'h3);
      addVec(1'b1, 4'h5, 3, 0, 4'h9, 4'h3);
    end
    addVec(1'b0, 4'h5, 6, 0, 4'h9, 4'h3);
    addVec(1'b1, 4'h8, 5, 1, 4'h8, 4'h9);
    addVec(1'b0, 4'h8, 2, 0, 4'h8, 4'h9);
    addVec(1'b1, 4'h8, 10, 0, 4'h8, 4'h9);
    addVec(1'b0, 4'h8, 6, 0, 4'h8, 4'h9);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].kv, vecs[n].key, 1'b0, 1'b0, 1'b0);
      ev = 0;
      for (int c = 0; c < vecs[n].cycles; c++) begin
        tick();
        if (key_event) ev++;
      end
      checkOutput($sformatf("vec%0d_events", n), ev, vecs[n].exp_events);
      checkOutput($sformatf("vec%0d_right", n), digit_right, vecs[n].exp_right);
      checkOutput($sformatf("vec%0d_left", n), digit_left, vecs[n].exp_left);
      checkOutput($sformatf("vec%0d_disp", n), disp_val, vecs[n].exp_right);
    end

    // Manual toggle selects the left digit.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_chip_sel_left", chip_sel, 1'b1);
    checkOutput("t2_disp_left", disp_val, 4'h9);

    // Auto mode: five toggles in 50 cycles, each 10 cycles apart.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    toggles = 0;
    last_toggle = -1;
    bad_gap = 0;
    prev_chip = chip_sel;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (chip_sel !== prev_chip) begin
        toggles++;
        if (last_toggle >= 0 && (i - last_toggle) != DIV) bad_gap++;
        last_toggle = i;
      end
      prev_chip = chip_sel;
    end
    checkOutput("t5_auto_toggles", toggles, 5);
    checkOutput("t5_auto_bad_gaps", bad_gap, 0);

    // Manual mode: counter wraps do nothing, each pulse toggles once.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    toggles = 0;
    prev_chip = chip_sel;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (chip_sel !== prev_chip) toggles++;
      prev_chip = chip_sel;
    end
    checkOutput("t5_manual_idle_toggles", toggles, 0);
    toggles = 0;
    for (int p = 0; p < 3; p++) begin
      sel_toggle = 1'b1;
      tick();
      sel_toggle = 1'b0;
      if (chip_sel !== prev_chip) toggles++;
      prev_chip = chip_sel;
      tick();
      tick();
      if (chip_sel !== prev_chip) toggles++;
      prev_chip = chip_sel;
    end
    checkOutput("t5_manual_pulse_toggles", toggles, 3);

    // Clear on the capture edge of key A: digits zeroed, event still fires.
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) tick();
    checkOutput("t6_no_early_event", key_event, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("t6_clear_event", key_event, 1'b1);
    checkOutput("t6_clear_right", digit_right, 4'h0);
    checkOutput("t6_clear_left", digit_left, 4'h0);
    applyStimulus(1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();

    // Capture C so reset has something to clear, then reset mid-QUALIFY.
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HOLD; i++) tick();
    checkOutput("t6_capture_c", digit_right, 4'hC);
    applyStimulus(1'b0, 4'hC, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      sel_toggle = 1'b0;
    end
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_right", digit_right, 4'h0);
    checkOutput("t6_rst_chip_sel", chip_sel, 1'b0);
    checkOutput("t6_rst_disp", disp_val, 4'h0);
    checkOutput("t6_rst_event", key_event, 1'b0);
    tick();
    rst = 1'b0;
    ev = 0;
    for (int i = 0; i < HOLD - 2; i++) begin
      tick();
      if (key_event) ev++;
    end
    checkOutput("t6_partial_discarded", ev, 0);
    checkOutput("t6_post_rst_right", digit_right, 4'h0);

    // Randomized run against the behavioural model.
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    compare_model = 1'b1;
    seg_left = 0;
    seg_kv = 1'b0;
    seg_key = 4'h0;
    rand_am = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (seg_left == 0) begin
        seg_kv   = 1'($urandom_range(0, 1));
        seg_key  = 4'($urandom_range(0, 3));
        seg_left = $urandom_range(1, 12);
      end
      seg_left--;
      if ($urandom_range(0, 99) == 0) rand_am = ~rand_am;
      applyStimulus(seg_kv,
                    ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : seg_key,
                    1'($urandom_range(0, 49) == 0), rand_am,
                    1'($urandom_range(0, 7) == 0));
      rst = 1'($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    compare_model = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ssd_digit_mux.md
Name: ssd_digit_mux

Overview:
Sits between keypad_decoder and disp_ctrl on the Pmod SSD path. It qualifies raw key presses and shifts each accepted key into a two-digit buffer. It then drives chip_sel, either time-multiplexed at a refresh rate or toggled manually. It presents the selected digit nibble to disp_ctrl.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz.
REFRESH_HZ, 1000, digit toggle rate in auto mode; DIV = CLK_FREQ/REFRESH_HZ cycles per digit.
HOLD_MS, 20, press/release stability window; HOLD = (CLK_FREQ/1000)*HOLD_MS cycles.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
key_val  input  4  decoded key code from keypad_decoder.
key_valid  input  1  is_a_key_pressed from keypad_decoder.
clear  input  1  synchronous single-cycle pulse; zeroes both digits.
auto_mux  input  1  1 = refresh-driven chip_sel; 0 = manual.
sel_toggle  input  1  single-cycle pulse; toggles chip_sel in manual mode only.
disp_val  output  4  nibble to disp_ctrl.
chip_sel  output  1  digit select to SSD; 0 = right digit, 1 = left digit.
key_event  output  1  one-cycle pulse when a key is accepted.
digit_right  output  4  most recent accepted key.
digit_left  output  4  previous accepted key.

Behaviour:
- Reset (async, rst=1):
  - digit_right = digit_left = 0; chip_sel = 0; key_event = 0.
  - FSM = IDLE; hold counter = 0; refresh counter = 0.
- Key FSM states: IDLE, QUALIFY, CAPTURED, RELEASE.
  - IDLE: key_valid=1 → QUALIFY. Latch key_val into cand; cnt=1.
  - QUALIFY, key_valid=0 → IDLE.
  - QUALIFY, key_val≠cand → stay. Cand=key_val, cnt=1.
  - QUALIFY, otherwise cnt++. When cnt reaches HOLD → CAPTURED. Same edge: digit_left<=digit_right, digit_right<=cand, key_event=1 for that one cycle.
  - CAPTURED: key_valid=0 → RELEASE, cnt=1. No further captures while the key is held, so there is no auto-repeat.
  - RELEASE, key_valid=1 → CAPTURED (bounce).
  - RELEASE, otherwise cnt++. When cnt reaches HOLD → IDLE.
- Capture latency: key_event asserts HOLD cycles after the first cycle key_valid=1 with a stable key_val.
- Clear:
  - digits zeroed on the next edge.
  - If clear coincides with capture: clear wins, digits = 0, and key_event still pulses.
  - FSM state is unaffected by clear.
- Refresh counter:
  - Free-runs 0..DIV-1, then wraps to 0.
  - At wrap with auto_mux=1, chip_sel toggles.
  - Counter runs regardless of mode.
- Manual mode (auto_mux=0): sel_toggle=1 toggles chip_sel. sel_toggle is ignored when auto_mux=1.
- Mode change: chip_sel holds its current value. The refresh counter is not reset.
- disp_val = chip_sel ? digit_left : digit_right. Combinational from registered state, so zero latency relative to chip_sel/digits.
- Counter widths: $clog2(DIV) and $clog2(HOLD+1). No overflow; the hold counter saturates at HOLD.
- rst asserted mid-QUALIFY or mid-RELEASE: FSM to IDLE immediately. A partially qualified key is discarded.

Test Plan:
Bench parameters: CLK_FREQ=1000, REFRESH_HZ=100, HOLD_MS=5 → DIV=10, HOLD=5.
1. Reset, then key_valid=1, key_val=4'h7 held 20 cycles, then released → key_event one pulse exactly 5 cycles after key_valid rise; digit_right=7, digit_left=0.
2. Press 3 (held ≥5 cycles, released ≥5 cycles), then press 9 → digit_right=9, digit_left=3; disp_val=9 when chip_sel=0 and 3 when chip_sel=1.
3. key_valid=1 with key_val alternating 2,5 every 3 cycles for 30 cycles → no key_event; digits unchanged.
4. Hold key 8 for 5 cycles, drop key_valid 2 cycles, reassert 10 cycles, release → exactly one key_event; digit_right=8.
5. auto_mux=1 for 50 cycles → chip_sel toggles every 10 cycles (5 toggles). Then auto_mux=0 with sel_toggle pulses → one toggle per pulse; no toggles on counter wrap.
6. Assert clear on the same cycle as a capture of key A → digits = 0 and key_event=1. Assert rst during QUALIFY → no capture, all outputs at reset values.
